// File: rtl/apb_reg_slave.sv
// apb_reg_slave
// APB completer with a small memory-mapped register bank, byte-strobed writes
// and a configurable number of wait states before pready.
//
// Ports:
//   pclk, preset_n       bus clock, synchronous active-low reset
//   paddr, pprot, psel,  APB request bundle (pprot is accepted and ignored)
//   penable, pwrite,
//   pwdata, pstrb
//   pready, prdata,      APB response bundle, all registered; prdata and
//   pslverr              pslverr are 0 whenever pready is 0
//   reg_out              flat register contents, slot i at [i*DATA_LENGTH +: DATA_LENGTH];
//                        slot 0 carries ID_VALUE
//
// state  | meaning
// IDLE   | no transfer; waiting for a setup phase (psel=1, penable=0)
// ACCESS | access phase, counting down wait states; psel low aborts
// RESP   | pready=1 for one cycle; a write commits at the edge ending it
module apb_reg_slave #(
   parameter int                     DATA_LENGTH = 32,
   parameter int                     NUM_REGS    = 8,
   parameter int                     WAIT_CYCLES = 0,
   parameter logic [DATA_LENGTH-1:0] ID_VALUE    = 32'h4150_4231
) (
   input  logic                            pclk,
   input  logic                            preset_n,
   input  logic [DATA_LENGTH-1:0]          paddr,
   input  logic [2:0]                      pprot,
   input  logic                            psel,
   input  logic                            penable,
   input  logic                            pwrite,
   input  logic [DATA_LENGTH-1:0]          pwdata,
   input  logic [3:0]                      pstrb,
   output logic                            pready,
   output logic [DATA_LENGTH-1:0]          prdata,
   output logic                            pslverr,
   output logic [NUM_REGS*DATA_LENGTH-1:0] reg_out
);

   localparam int IW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                 state;
   logic [3:0]             wcnt;
   logic [IW-1:0]          idx_q;
   logic                   err_q;
   logic                   write_q;
   logic [DATA_LENGTH-1:0] wdata_q;
   logic [3:0]             strb_q;
   logic [DATA_LENGTH-1:0] bank [NUM_REGS];

   logic                   unused_pprot;
   assign unused_pprot = ^pprot;

   // Decode of the request currently on the bus (meaningful in a setup phase)
   logic                   setup;
   logic                   legal;
   logic [IW-1:0]          s_idx;
   logic                   s_err;

   assign setup = psel && !penable;
   assign legal = (paddr[1:0] == 2'b00) &&
                  ({2'b00, paddr[DATA_LENGTH-1:2]} < DATA_LENGTH'(NUM_REGS));
   assign s_idx = paddr[IW+1:2];
   assign s_err = !legal || (pwrite && (s_idx == '0));

   // Pending write merged with the current register contents
   logic                   commit;
   logic [DATA_LENGTH-1:0] wmerge;

   assign commit = (state == RESP) && write_q && !err_q;

   always_comb begin
      wmerge = bank[idx_q];
      for (int b = 0; b < 4; b++) begin
         if (strb_q[b]) wmerge[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   // With zero wait states the response is built straight from the setup
   // decode; otherwise from the request latched at setup.
   logic [IW-1:0]          r_idx;
   logic                   r_err;
   logic                   r_write;
   logic [DATA_LENGTH-1:0] rd_val;

   assign r_idx   = (state == ACCESS) ? idx_q   : s_idx;
   assign r_err   = (state == ACCESS) ? err_q   : s_err;
   assign r_write = (state == ACCESS) ? write_q : pwrite;

   // A back-to-back read set up during RESP samples on the same edge the
   // previous write commits, so that write is forwarded.
   always_comb begin
      rd_val = '0;
      if (!r_err && !r_write) begin
         if (r_idx == '0)                   rd_val = ID_VALUE;
         else if (commit && r_idx == idx_q) rd_val = wmerge;
         else                               rd_val = bank[r_idx];
      end
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state   <= IDLE;
         wcnt    <= '0;
         pready  <= 1'b0;
         prdata  <= '0;
         pslverr <= 1'b0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         pready  <= 1'b0;
         prdata  <= '0;
         pslverr <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (setup) begin
                  idx_q   <= s_idx;
                  err_q   <= s_err;
                  write_q <= pwrite;
                  wdata_q <= pwdata;
                  strb_q  <= pstrb;
                  // The first access cycle is itself a wait cycle, so the
                  // counter starts one lower; zero waits answer immediately.
                  if (WAIT_CYCLES == 0) begin
                     state   <= RESP;
                     pready  <= 1'b1;
                     prdata  <= rd_val;
                     pslverr <= s_err;
                  end else begin
                     state <= ACCESS;
                     wcnt  <= 4'(WAIT_CYCLES - 1);
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               if (!psel) begin
                  state <= IDLE;
               end else if (wcnt != '0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  state   <= RESP;
                  pready  <= 1'b1;
                  prdata  <= rd_val;
                  pslverr <= err_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
      end else if (commit) begin
         bank[idx_q] <= wmerge;
      end
   end

   always_comb begin
      reg_out = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_out[i*DATA_LENGTH +: DATA_LENGTH] = (i == 0) ? ID_VALUE : bank[i];
      end
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
module tb_apb_reg_slave;

   localparam logic [31:0] ID = 32'h4150_4231;

   logic        pclk = 1'b0;
   logic        preset_n = 1'b1;
   logic [31:0] paddr = '0;
   logic [2:0]  pprot = '0;
   logic        psel0 = 1'b0;
   logic        psel3 = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;

   logic        pready0, pslverr0, pready3, pslverr3;
   logic [31:0] prdata0, prdata3;
   logic [255:0] reg_out0, reg_out3;

   int errors = 0;
   int checks = 0;

   always #5 pclk = ~pclk;

   apb_reg_slave #(.DATA_LENGTH(32), .NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut0 (
      .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot), .psel(psel0),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready0), .prdata(prdata0), .pslverr(pslverr0), .reg_out(reg_out0));

   apb_reg_slave #(.DATA_LENGTH(32), .NUM_REGS(8), .WAIT_CYCLES(3), .ID_VALUE(ID)) u_dut3 (
      .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot), .psel(psel3),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready3), .prdata(prdata3), .pslverr(pslverr3), .reg_out(reg_out3));

   // One complete transfer; returns immediately after observing pready so the
   // next call starts a back-to-back setup phase.
   task automatic apb_xfer(input bit use3, input logic [31:0] addr, input bit wr,
                           input logic [31:0] wd, input logic [3:0] st,
                           output logic [31:0] rd, output logic err, output int lat);
      logic rdy;
      @(posedge pclk); #1;
      paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; penable = 1'b0;
      psel0 = !use3; psel3 = use3;
      @(negedge pclk);
      rdy = use3 ? pready3 : pready0;
      checks++;
      if (rdy !== 1'b0) begin
         errors++;
         $display("FAIL setup_pready addr=%h got=%b want=0", addr, rdy);
      end
      lat = 0; rd = '0; err = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge pclk);
         rdy = use3 ? pready3 : pready0;
         if (rdy === 1'b1) begin
            lat = n;
            rd  = use3 ? prdata3 : prdata0;
            err = use3 ? pslverr3 : pslverr0;
            break;
         end
         @(posedge pclk); #1;
      end
      if (lat == 0) begin
         checks++;
         errors++;
         $display("FAIL timeout addr=%h got=no_pready want=pready", addr);
      end
   endtask

   task automatic bus_idle();
      @(posedge pclk); #1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge pclk); #1 preset_n = 1'b0;
      repeat (2) @(posedge pclk);
      #1 preset_n = 1'b1;
      @(negedge pclk);
      checks++;
      if ({pready0, pslverr0, pready3, pslverr3} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got=%b want=0000", {pready0, pslverr0, pready3, pslverr3});
      end
      checks++;
      if (prdata0 !== 32'h0 || prdata3 !== 32'h0) begin
         errors++; $display("FAIL reset_prdata got=%h/%h want=0", prdata0, prdata3);
      end
      checks++;
      if (reg_out0[255:32] !== '0 || reg_out3[255:32] !== '0) begin
         errors++; $display("FAIL reset_regs got=%h want=0", reg_out0[255:32]);
      end
      checks++;
      if (reg_out0[31:0] !== ID) begin
         errors++; $display("FAIL reset_id_slot got=%h want=%h", reg_out0[31:0], ID);
      end
   endtask

   task automatic test_roundtrip();
      logic [31:0] rd; logic err; int lat;
      apb_xfer(0, 32'h04, 1, 32'hDEAD_BEEF, 4'hF, rd, err, lat);
      checks++;
      if (lat !== 1 || err !== 1'b0) begin
         errors++; $display("FAIL wr_latency got=lat%0d err%b want=lat1 err0", lat, err);
      end
      bus_idle();
      @(negedge pclk);
      checks++;
      if (reg_out0[63:32] !== 32'hDEAD_BEEF || prdata0 !== 32'h0) begin
         errors++; $display("FAIL reg_out1 got=%h prdata=%h want=deadbeef/0", reg_out0[63:32], prdata0);
      end
      apb_xfer(0, 32'h04, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
         errors++; $display("FAIL rd_reg1 got=%h err%b want=deadbeef err0", rd, err);
      end
      apb_xfer(0, 32'h00, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'h4150_4231 || err !== 1'b0) begin
         errors++; $display("FAIL rd_id got=%h err%b want=41504231 err0", rd, err);
      end
      bus_idle();
   endtask

   task automatic test_strobes();
      logic [31:0] rd; logic err; int lat;
      apb_xfer(0, 32'h04, 1, 32'h1122_3344, 4'b0101, rd, err, lat);
      apb_xfer(0, 32'h04, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'hDE22_BE44) begin
         errors++; $display("FAIL strobe_0101 got=%h want=de22be44", rd);
      end
      apb_xfer(0, 32'h04, 1, 32'hFFFF_FFFF, 4'b0000, rd, err, lat);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL strobe_none_err got=%b want=0", err);
      end
      apb_xfer(0, 32'h04, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'hDE22_BE44) begin
         errors++; $display("FAIL strobe_none got=%h want=de22be44", rd);
      end
      apb_xfer(0, 32'h1C, 1, 32'h7777_0007, 4'b1000, rd, err, lat);
      apb_xfer(0, 32'h1C, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'h7700_0000 || err !== 1'b0) begin
         errors++; $display("FAIL last_reg got=%h err%b want=77000000 err0", rd, err);
      end
      bus_idle();
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic err; int lat;
      apb_xfer(0, 32'h00, 1, 32'h1234_5678, 4'hF, rd, err, lat);
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL wr_id_err got=%b want=1", err);
      end
      apb_xfer(0, 32'h00, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== ID || err !== 1'b0) begin
         errors++; $display("FAIL id_unchanged got=%h err%b want=%h err0", rd, err, ID);
      end
      apb_xfer(0, 32'h20, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'h0 || err !== 1'b1) begin
         errors++; $display("FAIL rd_oob got=%h err%b want=0 err1", rd, err);
      end
      apb_xfer(0, 32'h06, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (err !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL rd_unaligned got=%h err%b want=0 err1", rd, err);
      end
      apb_xfer(0, 32'h08, 1, 32'hAAAA_AAAA, 4'hF, rd, err, lat);
      apb_xfer(0, 32'h0A, 1, 32'h5555_5555, 4'hF, rd, err, lat);
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL wr_unaligned_err got=%b want=1", err);
      end
      apb_xfer(0, 32'h08, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'hAAAA_AAAA) begin
         errors++; $display("FAIL wr_unaligned_nochange got=%h want=aaaaaaaa", rd);
      end
      bus_idle();
   endtask

   task automatic test_no_setup();
      logic seen = 1'b0;
      @(posedge pclk); #1;
      paddr = 32'h04; pwrite = 1'b0; psel0 = 1'b1; penable = 1'b1;
      repeat (4) begin
         @(negedge pclk);
         if (pready0 !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL no_setup got=pready want=none");
      end
      bus_idle();
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; logic err; int lat;
      logic seen = 1'b0;
      apb_xfer(1, 32'h04, 1, 32'h1234_5678, 4'hF, rd, err, lat);
      checks++;
      if (lat !== 4 || err !== 1'b0) begin
         errors++; $display("FAIL wait_latency got=lat%0d err%b want=lat4 err0", lat, err);
      end
      bus_idle();
      // abort a write by dropping psel in the second wait cycle
      @(posedge pclk); #1;
      paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      psel3 = 1'b1; penable = 1'b0;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
      repeat (6) begin
         @(negedge pclk);
         if (pready3 !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL abort_pready got=pready want=none");
      end
      apb_xfer(1, 32'h04, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'h1234_5678 || lat !== 4) begin
         errors++; $display("FAIL abort_nowrite got=%h lat%0d want=12345678 lat4", rd, lat);
      end
      bus_idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic err; int lat;
      apb_xfer(0, 32'h08, 1, 32'hCAFE_F00D, 4'hF, rd, err, lat);
      apb_xfer(0, 32'h08, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'hCAFE_F00D || lat !== 1) begin
         errors++; $display("FAIL b2b_w0 got=%h lat%0d want=cafef00d lat1", rd, lat);
      end
      apb_xfer(1, 32'h08, 1, 32'h0BAD_CAFE, 4'hF, rd, err, lat);
      apb_xfer(1, 32'h08, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'h0BAD_CAFE || lat !== 4) begin
         errors++; $display("FAIL b2b_w3 got=%h lat%0d want=0badcafe lat4", rd, lat);
      end
      bus_idle();
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd; logic err; int lat;
      @(posedge pclk); #1;
      paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
      psel0 = 1'b1; penable = 1'b0;
      @(posedge pclk); #1 penable = 1'b1;
      @(negedge pclk);
      checks++;
      if (pready0 !== 1'b1) begin
         errors++; $display("FAIL resp_cycle got=%b want=1", pready0);
      end
      preset_n = 1'b0;
      @(posedge pclk); #1;
      preset_n = 1'b1; psel0 = 1'b0; penable = 1'b0;
      @(negedge pclk);
      checks++;
      if (reg_out0[127:96] !== 32'h0 || pready0 !== 1'b0) begin
         errors++; $display("FAIL rst_mid_slot got=%h rdy%b want=0 rdy0", reg_out0[127:96], pready0);
      end
      apb_xfer(0, 32'h0C, 0, 32'h0, 4'h0, rd, err, lat);
      checks++;
      if (rd !== 32'h0 || err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_read got=%h err%b want=0 err0", rd, err);
      end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_roundtrip();
      test_strobes();
      test_errors();
      test_no_setup();
      test_wait_states();
      test_back_to_back();
      test_reset_mid_write();
      repeat (2) @(posedge pclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
